// File: rtl/pb_field_if.sv
// Field-request and encoded-byte stream bundle for the protobuf field encoder.
interface pb_field_if #(
    parameter int unsigned FIELD_NUM_W = 29,
    parameter int unsigned VALUE_W     = 64
);
    logic                   in_valid;
    logic                   in_ready;
    logic [FIELD_NUM_W-1:0] in_field_number;
    logic [2:0]             in_wire_type;
    logic [VALUE_W-1:0]     in_value;
    logic                   in_zigzag;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_data;
    logic                   out_last;
    logic                   err_wire_type;
    logic                   err_field_zero;

    modport slave (
        input  in_valid, in_field_number, in_wire_type, in_value, in_zigzag, out_ready,
        output in_ready, out_valid, out_data, out_last, err_wire_type, err_field_zero
    );

    modport master (
        output in_valid, in_field_number, in_wire_type, in_value, in_zigzag, out_ready,
        input  in_ready, out_valid, out_data, out_last, err_wire_type, err_field_zero
    );
endinterface

// File: rtl/pb_field_encoder.sv
// Protobuf field encoder: one (field, wire type, value) request in, key varint plus
// varint/fixed32/fixed64 payload out as a byte stream with a last-byte marker.
module pb_field_encoder #(
    parameter int unsigned FIELD_NUM_W = 29,
    parameter int unsigned VALUE_W     = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    pb_field_if.slave bus
);
    localparam int unsigned KEY_W   = FIELD_NUM_W + 3;
    localparam int unsigned KCNT_W  = 3;
    localparam int unsigned VCNT_W  = 4;
    localparam int unsigned KEY_MAX = 5;
    localparam int unsigned VAL_MAX = 10;

    typedef enum logic [1:0] {IDLE, KEY, VAL} state_e;
    typedef enum logic [1:0] {PL_VARINT, PL_FIX64, PL_FIX32} payload_e;

    state_e              state_q, state_d;
    payload_e            kind_q, kind_d;
    logic [KEY_W-1:0]    key_sr_q, key_sr_d;
    logic [VALUE_W-1:0]  val_sr_q, val_sr_d;
    logic [KCNT_W-1:0]   key_cnt_q, key_cnt_d;
    logic [VCNT_W-1:0]   val_cnt_q, val_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                err_wt_q, err_wt_d;
    logic                err_fz_q, err_fz_d;

    logic                fire_out, in_ready_c, accept, bad_wt, bad_fz;
    logic [KEY_W-1:0]    key_in;
    logic [VALUE_W-1:0]  val_in, val_shift;
    logic [KCNT_W-1:0]   key_cnt_inc;
    logic [VCNT_W-1:0]   val_cnt_inc;
    logic                key_more, val_more, val_last;
    logic [7:0]          val_byte;

    assign bus.in_ready       = in_ready_c;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_last       = out_last_q;
    assign bus.err_wire_type  = err_wt_q;
    assign bus.err_field_zero = err_fz_q;

    // Shift registers always hold what remains after the byte currently on out_data.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        key_sr_d    = key_sr_q;
        val_sr_d    = val_sr_q;
        key_cnt_d   = key_cnt_q;
        val_cnt_d   = val_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        err_wt_d    = 1'b0;
        err_fz_d    = 1'b0;
        val_more    = 1'b0;

        fire_out   = out_valid_q & bus.out_ready;
        in_ready_c = (state_q == IDLE) | (fire_out & out_last_q);
        accept     = bus.in_valid & in_ready_c;
        bad_fz     = (bus.in_field_number == '0);
        bad_wt     = !((bus.in_wire_type == 3'd0) || (bus.in_wire_type == 3'd1) ||
                       (bus.in_wire_type == 3'd5));
        key_in     = {bus.in_field_number, bus.in_wire_type};
        val_in     = ((bus.in_wire_type == 3'd0) && bus.in_zigzag)
                   ? ((bus.in_value << 1) ^ {VALUE_W{bus.in_value[VALUE_W-1]}})
                   : bus.in_value;

        key_cnt_inc = (key_cnt_q == KCNT_W'(KEY_MAX)) ? key_cnt_q : key_cnt_q + KCNT_W'(1);
        val_cnt_inc = (val_cnt_q == VCNT_W'(VAL_MAX)) ? val_cnt_q : val_cnt_q + VCNT_W'(1);
        key_more    = (|key_sr_q[KEY_W-1:7]) && (key_cnt_inc != KCNT_W'(KEY_MAX));

        // Next payload byte, shared by the key-to-value step and value continuation.
        if (kind_q == PL_VARINT) begin
            val_more  = (|val_sr_q[VALUE_W-1:7]) && (val_cnt_inc != VCNT_W'(VAL_MAX));
            val_byte  = {val_more, val_sr_q[6:0]};
            val_shift = val_sr_q >> 7;
            val_last  = !val_more;
        end else begin
            val_byte  = val_sr_q[7:0];
            val_shift = val_sr_q >> 8;
            val_last  = (val_cnt_inc == ((kind_q == PL_FIX64) ? VCNT_W'(8) : VCNT_W'(4)));
        end

        case (state_q)
            KEY: begin
                if (fire_out) begin
                    if (!out_data_q[7]) begin
                        out_data_d = val_byte;
                        out_last_d = val_last;
                        val_sr_d   = val_shift;
                        val_cnt_d  = val_cnt_inc;
                        state_d    = VAL;
                    end else begin
                        out_data_d = {key_more, key_sr_q[6:0]};
                        key_sr_d   = key_sr_q >> 7;
                        key_cnt_d  = key_cnt_inc;
                    end
                end
            end
            VAL: begin
                if (fire_out) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        out_data_d = val_byte;
                        out_last_d = val_last;
                        val_sr_d   = val_shift;
                        val_cnt_d  = val_cnt_inc;
                    end
                end
            end
            default: ;
        endcase

        // A new request overrides the idle transition; illegal ones only pulse an error.
        if (accept) begin
            err_fz_d = bad_fz;
            err_wt_d = bad_wt;
            if (!bad_fz && !bad_wt) begin
                state_d     = KEY;
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                out_data_d  = {|key_in[KEY_W-1:7], key_in[6:0]};
                key_sr_d    = key_in >> 7;
                key_cnt_d   = KCNT_W'(1);
                val_sr_d    = val_in;
                val_cnt_d   = '0;
                kind_d      = (bus.in_wire_type == 3'd1) ? PL_FIX64 :
                              (bus.in_wire_type == 3'd5) ? PL_FIX32 : PL_VARINT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kind_q      <= PL_VARINT;
            key_sr_q    <= '0;
            val_sr_q    <= '0;
            key_cnt_q   <= '0;
            val_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_wt_q    <= 1'b0;
            err_fz_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            key_sr_q    <= key_sr_d;
            val_sr_q    <= val_sr_d;
            key_cnt_q   <= key_cnt_d;
            val_cnt_q   <= val_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            err_wt_q    <= err_wt_d;
            err_fz_q    <= err_fz_d;
        end
    end
endmodule
